// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types for the FIFO drain path (word packer FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [0:0] {
        ACC_FILL = 1'b0,
        ACC_WAIT = 1'b1
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer_if
// Description : FIFO read port plus packed valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_word_packer_if #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
);
    localparam int OUT_W = DATA_W * RATIO;
    localparam int CNT_W = $clog2(RATIO + 1);

    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_data_i;
    logic              fifo_pop_o;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OUT_W-1:0]  out_data_o;
    logic [CNT_W-1:0]  out_count_o;

    modport master (
        input  fifo_empty_i, fifo_data_i, flush_i, out_ready_i,
        output fifo_pop_o, out_valid_o, out_data_o, out_count_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_i, flush_i, out_ready_i,
        input  fifo_pop_o, out_valid_o, out_data_o, out_count_o
    );

endinterface
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer
// Description : Drains a show-ahead FIFO and packs RATIO words per output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fifo_word_packer_if.master bus
);

    localparam int OUT_W = DATA_W * RATIO;
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(RATIO);

    logic [DATA_W-1:0] r_lane [RATIO];
    logic [CNT_W-1:0]  r_count;
    logic              r_flush_pend;
    acc_state_t        r_state;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic [CNT_W-1:0]  r_out_count;

    logic              w_out_free;
    logic              w_flush_eff;
    logic              w_full;
    logic              w_acc_empty;
    logic              w_xfer;
    logic              w_flush_drop;
    logic              w_pop;
    logic              w_pend_nxt;
    logic [CNT_W-1:0]  w_wr_idx;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [OUT_W-1:0]  w_packed;

    assign w_out_free   = !r_out_valid || bus.out_ready_i;
    assign w_flush_eff  = bus.flush_i || r_flush_pend;
    assign w_full       = (r_count == c_full);
    assign w_acc_empty  = (r_count == '0);
    assign w_xfer       = w_out_free && (w_full || (w_flush_eff && !w_acc_empty));
    assign w_flush_drop = w_flush_eff && w_acc_empty;

    // ACC_WAIT means full or flush pending; a full accumulator may still pop
    // in the cycle it hands its word off, keeping one pop per clock.
    assign w_pop = !reset && !bus.fifo_empty_i && !w_flush_eff &&
                   ((r_state == ACC_FILL) || w_xfer);

    assign w_wr_idx   = w_xfer ? '0 : r_count;
    assign w_pend_nxt = (w_xfer || w_flush_drop) ? 1'b0 : (r_flush_pend || bus.flush_i);

    always_comb begin
        w_count_nxt = r_count;
        if (w_xfer) begin
            w_count_nxt = w_pop ? CNT_W'(1) : '0;
        end else if (w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Lanes beyond the fill count are zeroed so a partial beat has clean MSBs.
    always_comb begin
        w_packed = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) < r_count) begin
                w_packed[i*DATA_W +: DATA_W] = r_lane[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RATIO; i++) begin
                r_lane[i] <= '0;
            end
            r_count      <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= ACC_FILL;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_count  <= '0;
        end else begin
            for (int i = 0; i < RATIO; i++) begin
                if (w_pop && (w_wr_idx == CNT_W'(i))) begin
                    r_lane[i] <= bus.fifo_data_i;
                end
            end
            r_count      <= w_count_nxt;
            r_flush_pend <= w_pend_nxt;
            r_state      <= ((w_count_nxt == c_full) || w_pend_nxt) ? ACC_WAIT : ACC_FILL;

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_packed;
                r_out_count <= r_count;
            end else if (bus.out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_pop_o  = w_pop;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_count_o = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_word_packer
// Description : Directed and randomized bench with an upstream FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

    localparam int DATA_W = 8;
    localparam int RATIO  = 4;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  c;
        int          t;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_word_packer_if #(.DATA_W(DATA_W), .RATIO(RATIO)) bus ();

    fifo_word_packer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Upstream show-ahead FIFO model
    logic [7:0] fq[$];
    logic       m_empty   = 1'b1;
    logic [7:0] m_data    = 8'h00;
    logic       push_req  = 1'b0;
    logic [7:0] push_data = 8'h00;
    assign bus.fifo_empty_i = m_empty;
    assign bus.fifo_data_i  = m_data;

    int    vectors = 0, miscompares = 0;
    int    cyc = 0, pop_cnt = 0, underflows = 0, hold_viol = 0;
    int    popcyc[$];
    beat_t rxq[$], expq[$];
    beat_t rb;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_d    = '0;
    logic [2:0]  prev_c    = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_pop_o) begin
            pop_cnt <= pop_cnt + 1;
            popcyc.push_back(cyc);
            if (fq.size() == 0) underflows <= underflows + 1;
            else                void'(fq.pop_front());
        end
        if (push_req && fq.size() < DEPTH) fq.push_back(push_data);
        m_empty <= (fq.size() == 0);
        m_data  <= (fq.size() == 0) ? 8'h00 : fq[0];

        if (bus.out_valid_o && bus.out_ready_i) begin
            rb.d = bus.out_data_o;
            rb.c = bus.out_count_o;
            rb.t = cyc;
            rxq.push_back(rb);
        end
        if (!reset && prev_hold &&
            (!bus.out_valid_o || bus.out_data_o !== prev_d || bus.out_count_o !== prev_c))
            hold_viol <= hold_viol + 1;
        prev_hold <= bus.out_valid_o && !bus.out_ready_i;
        prev_d    <= bus.out_data_o;
        prev_c    <= bus.out_count_o;
    end

    // Reference: words accumulate in push order; every RATIO words, or a flush
    // of a non-empty group, yields one beat with word k in byte lane k.
    logic [7:0] mw[$];

    task automatic model_emit();
        beat_t b;
        b.d = 32'h0;
        b.c = 3'(mw.size());
        b.t = 0;
        foreach (mw[i]) b.d = b.d + (32'(mw[i]) << (8 * i));
        expq.push_back(b);
        mw.delete();
    endtask

    task automatic model_push(input logic [7:0] w);
        mw.push_back(w);
        if (mw.size() == RATIO) model_emit();
    endtask

    task automatic model_flush();
        if (mw.size() != 0) model_emit();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, 64'(rxq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(rxq[i].d), 64'(expq[i].d));
            chk($sformatf("%s_count%0d", tag, i), 64'(rxq[i].c), 64'(expq[i].c));
        end
        rxq.delete();
        expq.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int g = 0;
        while (fq.size() >= DEPTH && g < 200) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            vectors++;
            miscompares++;
            $error("FAIL push_timeout observed=fifo_full expected=space");
        end
        push_req  = 1'b1;
        push_data = d;
        @(negedge clk);
        push_req  = 1'b0;
        model_push(d);
    endtask

    initial begin
        int p0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        // Reset state
        wait_cycles(3);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_data",  64'(bus.out_data_o),  64'd0);
        chk("rst_count", 64'(bus.out_count_o), 64'd0);
        chk("rst_pop",   64'(bus.fifo_pop_o),  64'd0);
        reset = 1'b0;

        // 1: single full beat and its latency
        bus.out_ready_i = 1'b1;
        popcyc.delete();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_cycles(10);
        chk("t1_pops", 64'(popcyc.size()), 64'd4);
        if (popcyc.size() == 4) chk("t1_pop_span", 64'(popcyc[3] - popcyc[0]), 64'd3);
        if (rxq.size() > 0 && popcyc.size() > 0)
            chk("t1_latency", 64'(rxq[0].t - popcyc[0]), 64'(RATIO + 1));
        check_beats("t1");

        // 2: backpressure holds the beat and stalls pops after 8 words
        bus.out_ready_i = 1'b0;
        p0 = pop_cnt;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_cycles(10);
        chk("t2_valid",  64'(bus.out_valid_o), 64'd1);
        chk("t2_data",   64'(bus.out_data_o),  64'h04030201);
        chk("t2_count",  64'(bus.out_count_o), 64'd4);
        wait_cycles(5);
        chk("t2_data_held", 64'(bus.out_data_o), 64'h04030201);
        chk("t2_pops",      64'(pop_cnt - p0),   64'd8);
        chk("t2_pop_stall", 64'(bus.fifo_pop_o), 64'd0);
        bus.out_ready_i = 1'b1;
        wait_cycles(12);
        check_beats("t2");

        // 3: flush of a partial word, then flush with nothing accumulated
        push(8'hAA); push(8'hBB);
        wait_cycles(4);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        model_flush();
        wait_cycles(6);
        check_beats("t3");
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        model_flush();
        wait_cycles(6);
        check_beats("t3_empty_flush");
        chk("t3_idle_valid", 64'(bus.out_valid_o), 64'd0);

        // 4: streaming at full throughput
        popcyc.delete();
        for (int i = 0; i < 12; i++) push(8'(8'h50 + i));
        wait_cycles(10);
        chk("t4_pops", 64'(popcyc.size()), 64'd12);
        if (popcyc.size() == 12) chk("t4_pop_span", 64'(popcyc[11] - popcyc[0]), 64'd11);
        if (rxq.size() == 3) begin
            chk("t4_gap0", 64'(rxq[1].t - rxq[0].t), 64'd4);
            chk("t4_gap1", 64'(rxq[2].t - rxq[1].t), 64'd4);
        end
        check_beats("t4");

        // 5: reset discards a partial accumulation
        push(8'hA1); push(8'hA2); push(8'hA3);
        wait_cycles(6);
        reset = 1'b1;
        mw.delete();
        @(negedge clk);
        chk("t5_rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("t5_rst_data",  64'(bus.out_data_o),  64'd0);
        chk("t5_rst_count", 64'(bus.out_count_o), 64'd0);
        push(8'hC1);
        chk("t5_rst_pop", 64'(bus.fifo_pop_o), 64'd0);
        reset = 1'b0;
        push(8'hC2); push(8'hC3); push(8'hC4);
        wait_cycles(10);
        check_beats("t5");

        // 6: sparse random pushes with random backpressure
        for (int n = 0; n < 40; n++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                bus.out_ready_i = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.out_ready_i = 1'($urandom_range(0, 1));
            push(8'($urandom_range(0, 255)));
        end
        bus.out_ready_i = 1'b1;
        wait_cycles(30);
        check_beats("t6");
        chk("no_underflow", 64'(underflows), 64'd0);
        chk("hold_stable",  64'(hold_viol),  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
